bcd_to_bin_seq: RTL and testbench
=================================

# bcd_to_bin_seq

Sequential BCD-to-binary converter: accepts a packed 4-digit BCD value (e.g. year digits set on the clock face) and returns its binary equivalent. It performs the inverse of the digit-extraction dividers, so edited digits can be written back into the binary time/date counters. It computes one digit per cycle using multiply-by-10-and-add, with a start/busy/done handshake.

## Interface
- N_DIGITS, 4, number of BCD digits converted, most-significant first.
- BIN_W, 14, binary result width; must satisfy 2^BIN_W > 10^N_DIGITS - 1 (14 for 4 digits).
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset; synchronous and active-high.
- start  input  1  conversion request; sampled only in IDLE.
- bcd_in  input  4*N_DIGITS  packed BCD, digit N_DIGITS-1 in the top nibble; sampled on the accepting edge only.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; result valid.
- bin_out  output  BIN_W  binary result; holds until the next done.
- err  output  1  set with done if any input nibble > 9; holds with bin_out.

## Operation
- States: IDLE, CONV, DONE.
- IDLE: if start=1 at an edge, latch bcd_in into the digit register. Clear the accumulator. Set digit index to N_DIGITS-1. Latch the invalid flag (OR of nibble > 9 over all digits). Go to CONV.
- CONV: each edge computes acc <= acc*10 + digit[index], where acc*10 = (acc<<3)+(acc<<1) at BIN_W bits. When index = 0, go to DONE; otherwise decrement index.
- Transition CONV->DONE, on the same edge:
  - Load bin_out with the final acc, or with 0 if the invalid flag is set.
  - Load err with the invalid flag.
  - Assert done.
- DONE: one cycle only. done deasserts and the block returns to IDLE at the next edge.
- start while busy: ignored, with no queueing. The requester must re-issue it after busy falls.
- Invalid digits still iterate the full N_DIGITS cycles, so latency is data-independent. Intermediate arithmetic wraps modulo 2^BIN_W and the result is discarded.
- bcd_in changing after acceptance has no effect.

## Timing
- Reset values: busy=0, done=0, bin_out=0, err=0, state=IDLE, accumulator and index = 0.
- Latency: start accepted at edge t, then the digit updates occur at edges t+1..t+N_DIGITS. done=1 during the cycle after edge t+N_DIGITS (t+4 by default).
- busy rises after edge t. It falls after edge t+N_DIGITS+1, the same edge at which done falls.
- Earliest next acceptance: edge t+N_DIGITS+2. Throughput is one conversion per N_DIGITS+2 cycles.
- bin_out and err change only on the CONV->DONE edge or on reset.
- rst=1 at any edge, including mid-CONV or during DONE:
  - All outputs and state go to their reset values.
  - No done is produced for the aborted conversion.
  - rst has priority over start on the same edge.

## Structure
- Shared package: state encoding (IDLE/CONV/DONE), BCD_W=4, BCD_MAX=9, defaults for N_DIGITS/BIN_W. The other clock-digit blocks reuse these.
- Sub-module mul10_add: combinational, (acc[BIN_W-1:0], digit[3:0]) -> acc*10+digit truncated to BIN_W, shift-add only, no multiplier. Everything else (FSM, index counter, registers) lives in bcd_to_bin_seq.

## Test plan
- Year value: bcd_in=16'h2024, start for 1 cycle -> done pulses exactly 4 cycles after the accepting edge, bin_out=2024 (14'h07E8), err=0, busy high for 5 cycles.
- Extremes, back-to-back: 16'h9999 then 16'h0000, each started at the earliest legal edge -> bin_out=9999 (14'h270F), then 0; err=0 both times.
- Invalid digit: bcd_in=16'h20A4 -> done after 4 cycles, bin_out=0, err=1. A following 16'h1999 yields 1999 and clears err.
- Start while busy: start held high for 8 cycles with 16'h0042, changed to 16'h0777 at cycle 2 -> exactly one conversion in the first window, bin_out=42. A second conversion is accepted at the earliest legal edge and yields 777.
- Reset mid-conversion: rst=1 at the 2nd CONV edge of 16'h1234 -> no done pulse, busy=0, bin_out=0 next cycle. A new start with 16'h0059 yields 59 with normal latency.
- Simultaneous rst and start in IDLE -> no conversion; outputs remain at reset values.

Source files
------------

// File: rtl/bcd_to_bin_seq_pkg.sv
// -----------------------------------------------------------------------------
// bcd_to_bin_seq_pkg
// Definitions shared by the clock-face digit blocks:
//   - conv_state_e : IDLE / CONV / DONE encoding of the digit converters
//   - BCD_W        : bits per BCD digit
//   - BCD_MAX      : largest legal BCD digit value
//   - DEF_N_DIGITS / DEF_BIN_W : default digit count and binary width
//   - bcd_digit_invalid() : flags a nibble that is not a decimal digit
// -----------------------------------------------------------------------------
package bcd_to_bin_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } conv_state_e;

    localparam int BCD_W        = 4;
    localparam int BCD_MAX      = 9;
    localparam int DEF_N_DIGITS = 4;
    // 2^14 = 16384 > 9999, the largest 4-digit BCD value.
    localparam int DEF_BIN_W    = 14;

    function automatic logic bcd_digit_invalid(input logic [BCD_W-1:0] digit);
        return (digit > BCD_W'(BCD_MAX));
    endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// -----------------------------------------------------------------------------
// bcd_to_bin_seq_if
// Request/response bundle of the BCD-to-binary converter.
//   start   : conversion request (requester -> converter)
//   bcd_in  : packed BCD digits, most-significant digit in the top nibble
//   busy    : converter not idle
//   done    : one-cycle pulse, bin_out/err valid
//   bin_out : binary result, held until the next done
//   err     : an input nibble was above 9, held with bin_out
// Modports: master = requester side, slave = converter side.
// -----------------------------------------------------------------------------
interface bcd_to_bin_seq_if
    import bcd_to_bin_seq_pkg::*;
#(
    parameter int N_DIGITS = DEF_N_DIGITS,
    parameter int BIN_W    = DEF_BIN_W
) ();

    logic                         start;
    logic [BCD_W*N_DIGITS-1:0]    bcd_in;
    logic                         busy;
    logic                         done;
    logic [BIN_W-1:0]             bin_out;
    logic                         err;

    modport master (
        output start,
        output bcd_in,
        input  busy,
        input  done,
        input  bin_out,
        input  err
    );

    modport slave (
        input  start,
        input  bcd_in,
        output busy,
        output done,
        output bin_out,
        output err
    );

endinterface

// File: rtl/bcd_to_bin_seq_mul10_add.sv
// -----------------------------------------------------------------------------
// bcd_to_bin_seq_mul10_add
// Combinational step of the converter: o_result = i_acc*10 + i_digit,
// truncated to BIN_W bits. The x10 is built from two shifts and an add
// ((acc<<3) + (acc<<1)), so no multiplier is inferred.
// Ports:
//   i_acc    [BIN_W-1:0] running accumulator
//   i_digit  [3:0]       next BCD digit (not range checked here)
//   o_result [BIN_W-1:0] acc*10 + digit modulo 2^BIN_W
// -----------------------------------------------------------------------------
module bcd_to_bin_seq_mul10_add
    import bcd_to_bin_seq_pkg::*;
#(
    parameter int BIN_W = DEF_BIN_W
) (
    input  logic [BIN_W-1:0] i_acc,
    input  logic [BCD_W-1:0] i_digit,
    output logic [BIN_W-1:0] o_result
);

    logic [BIN_W-1:0] w_acc_x8;
    logic [BIN_W-1:0] w_acc_x2;
    logic [BIN_W-1:0] w_digit_ext;

    assign w_acc_x8    = i_acc << 3;
    assign w_acc_x2    = i_acc << 1;
    assign w_digit_ext = BIN_W'(i_digit);

    // Overflow bits simply drop off; an oversize result only occurs for
    // invalid digits, whose result is discarded by the caller.
    assign o_result = w_acc_x8 + w_acc_x2 + w_digit_ext;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// -----------------------------------------------------------------------------
// bcd_to_bin_seq
// Sequential BCD-to-binary converter. One digit is folded into the
// accumulator per clock (acc = acc*10 + digit), most-significant first, so a
// conversion takes N_DIGITS cycles in CONV plus one DONE cycle regardless of
// the data. Used to write edited clock-face digits back into binary counters.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset, wins over start
//   bus : bcd_to_bin_seq_if.slave (start, bcd_in, busy, done, bin_out, err)
// -----------------------------------------------------------------------------
module bcd_to_bin_seq
    import bcd_to_bin_seq_pkg::*;
#(
    parameter int N_DIGITS = DEF_N_DIGITS,
    parameter int BIN_W    = DEF_BIN_W
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_to_bin_seq_if.slave       bus
);

    localparam int                IN_W     = BCD_W * N_DIGITS;
    localparam int                IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_DIGITS - 1);

    // ------------------------------------------------------------------
    // State and datapath registers with their next-state values
    // ------------------------------------------------------------------
    conv_state_e        r_state;
    conv_state_e        w_state_next;
    logic [IN_W-1:0]    r_digits;
    logic [IN_W-1:0]    w_digits_next;
    logic [BIN_W-1:0]   r_acc;
    logic [BIN_W-1:0]   w_acc_next;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_next;
    logic               r_invalid;
    logic               w_invalid_next;
    logic [BIN_W-1:0]   r_bin_out;
    logic [BIN_W-1:0]   w_bin_out_next;
    logic               r_err;
    logic               w_err_next;

    // ------------------------------------------------------------------
    // Digit slicing and input validity check
    // ------------------------------------------------------------------
    logic [BCD_W-1:0]    w_digit_arr [N_DIGITS];
    logic [N_DIGITS-1:0] w_nib_bad;
    logic                w_in_invalid;
    logic [BCD_W-1:0]    w_cur_digit;
    logic [BIN_W-1:0]    w_mac;

    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign w_digit_arr[gi] = r_digits[gi*BCD_W +: BCD_W];
            // Checked on the live input so the flag is captured on the
            // accepting edge together with the digits.
            assign w_nib_bad[gi]   = bcd_digit_invalid(bus.bcd_in[gi*BCD_W +: BCD_W]);
        end
    endgenerate

    assign w_in_invalid = |w_nib_bad;
    assign w_cur_digit  = w_digit_arr[r_idx];

    bcd_to_bin_seq_mul10_add #(
        .BIN_W    (BIN_W)
    ) u_mul10_add (
        .i_acc    (r_acc),
        .i_digit  (w_cur_digit),
        .o_result (w_mac)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_digits  <= '0;
            r_acc     <= '0;
            r_idx     <= '0;
            r_invalid <= 1'b0;
            r_bin_out <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_digits  <= w_digits_next;
            r_acc     <= w_acc_next;
            r_idx     <= w_idx_next;
            r_invalid <= w_invalid_next;
            r_bin_out <= w_bin_out_next;
            r_err     <= w_err_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_digits_next  = r_digits;
        w_acc_next     = r_acc;
        w_idx_next     = r_idx;
        w_invalid_next = r_invalid;
        w_bin_out_next = r_bin_out;
        w_err_next     = r_err;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_digits_next  = bus.bcd_in;
                    w_acc_next     = '0;
                    w_idx_next     = IDX_LAST;
                    w_invalid_next = w_in_invalid;
                    w_state_next   = ST_CONV;
                end
            end

            ST_CONV: begin
                // Invalid input still runs every digit so the latency does
                // not depend on the data; only the published result is masked.
                w_acc_next = w_mac;
                if (r_idx == '0) begin
                    w_bin_out_next = r_invalid ? '0 : w_mac;
                    w_err_next     = r_invalid;
                    w_state_next   = ST_DONE;
                end else begin
                    w_idx_next = r_idx - 1'b1;
                end
            end

            ST_DONE: begin
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.done    = (r_state == ST_DONE);
    assign bus.bin_out = r_bin_out;
    assign bus.err     = r_err;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// -----------------------------------------------------------------------------
// tb_bcd_to_bin_seq
// Self-checking bench for bcd_to_bin_seq. Expected results come from the
// decimal meaning of the BCD digits (sum of digit * 10^position); latency and
// pulse counts come from the documented timing.
// -----------------------------------------------------------------------------
module tb_bcd_to_bin_seq;

    localparam int N_DIGITS = 4;
    localparam int BIN_W    = 14;

    logic clk;
    logic rst;

    int n_checks;
    int n_fail;

    bcd_to_bin_seq_if #(.N_DIGITS(N_DIGITS), .BIN_W(BIN_W)) bus ();

    bcd_to_bin_seq #(
        .N_DIGITS (N_DIGITS),
        .BIN_W    (BIN_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the decimal value of the digits, or 0 with err if any
    // nibble is not a decimal digit.
    function automatic void model(input logic [15:0] bcd, output int val, output logic e);
        int pow10 [4];
        int d;
        pow10 = '{1, 10, 100, 1000};
        val = 0;
        e   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = int'(bcd[i*4 +: 4]);
            if (d > 9) e = 1'b1;
            val = val + d * pow10[i];
        end
        if (e) val = 0;
    endfunction

    // Issue one request from an idle DUT and observe it for N_DIGITS+1 edges
    // after acceptance; returns leaving the DUT idle so the next call is
    // accepted at the earliest legal edge.
    task automatic convert(input logic [15:0] bcd, output int lat, output int ndone,
                           output int nbusy, output logic [13:0] bin, output logic e);
        lat   = -1;
        ndone = 0;
        nbusy = 0;
        bin   = '0;
        e     = 1'b0;
        bus.start  = 1'b1;
        bus.bcd_in = bcd;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.bcd_in = 16'($urandom);
        if (bus.busy) nbusy++;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (bus.busy) nbusy++;
            if (bus.done) begin
                ndone++;
                if (lat < 0) begin
                    lat = k;
                    bin = bus.bin_out;
                    e   = bus.err;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.bcd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if ({bus.busy, bus.done, bus.err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: busy/done/err=%b expected 000", {bus.busy, bus.done, bus.err});
        end
        n_checks++;
        if (bus.bin_out !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_bin: bin_out=%0d expected 0", bus.bin_out);
        end
        $display("reset: busy=%b done=%b bin_out=%0d err=%b", bus.busy, bus.done, bus.bin_out, bus.err);
    endtask

    task automatic test_year();
        int lat, nd, nb;
        logic [13:0] bin;
        logic e;
        convert(16'h2024, lat, nd, nb, bin, e);
        $display("year: bcd=2024 lat=%0d done_pulses=%0d busy_cycles=%0d bin=%0d err=%b", lat, nd, nb, bin, e);
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("FAIL year_latency: got %0d expected 4", lat); end
        n_checks++;
        if (nd !== 1) begin n_fail++; $display("FAIL year_done_pulses: got %0d expected 1", nd); end
        n_checks++;
        if (nb !== 5) begin n_fail++; $display("FAIL year_busy_cycles: got %0d expected 5", nb); end
        n_checks++;
        if (bin !== 14'h07E8) begin n_fail++; $display("FAIL year_bin: got %0d expected 2024", bin); end
        n_checks++;
        if (e !== 1'b0) begin n_fail++; $display("FAIL year_err: got %b expected 0", e); end
        n_checks++;
        if (bus.bin_out !== 14'h07E8) begin n_fail++; $display("FAIL year_bin_hold: got %0d expected 2024", bus.bin_out); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [2];
        int lat, nd, nb, exp_v;
        logic [13:0] bin;
        logic e, exp_e;
        vals = '{16'h9999, 16'h0000};
        for (int i = 0; i < 2; i++) begin
            convert(vals[i], lat, nd, nb, bin, e);
            model(vals[i], exp_v, exp_e);
            $display("b2b: bcd=%h lat=%0d bin=%0d err=%b", vals[i], lat, bin, e);
            n_checks++;
            if (lat !== 4) begin n_fail++; $display("FAIL b2b_latency: bcd=%h got %0d expected 4", vals[i], lat); end
            n_checks++;
            if (bin !== 14'(exp_v) || e !== exp_e) begin
                n_fail++;
                $display("FAIL b2b_result: bcd=%h got %0d/%b expected %0d/%b", vals[i], bin, e, exp_v, exp_e);
            end
        end
    endtask

    task automatic test_invalid();
        int lat, nd, nb;
        logic [13:0] bin;
        logic e;
        convert(16'h20A4, lat, nd, nb, bin, e);
        $display("invalid: bcd=20a4 lat=%0d bin=%0d err=%b", lat, bin, e);
        n_checks++;
        if (lat !== 4) begin n_fail++; $display("FAIL invalid_latency: got %0d expected 4", lat); end
        n_checks++;
        if (bin !== 14'd0 || e !== 1'b1) begin
            n_fail++;
            $display("FAIL invalid_result: got %0d/%b expected 0/1", bin, e);
        end
        convert(16'h1999, lat, nd, nb, bin, e);
        $display("after_invalid: bcd=1999 lat=%0d bin=%0d err=%b", lat, bin, e);
        n_checks++;
        if (bin !== 14'd1999 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL recover_result: got %0d/%b expected 1999/0", bin, e);
        end
    endtask

    task automatic test_start_while_busy();
        int nd;
        int k_done [2];
        logic [13:0] b_done [2];
        nd = 0;
        k_done = '{-1, -1};
        b_done = '{14'd0, 14'd0};
        bus.start  = 1'b1;
        bus.bcd_in = 16'h0042;
        @(posedge clk); #1;
        for (int k = 1; k <= 12; k++) begin
            if (k == 2) bus.bcd_in = 16'h0777;
            if (k == 8) bus.start = 1'b0;
            @(posedge clk); #1;
            if (bus.done) begin
                if (nd < 2) begin
                    k_done[nd] = k;
                    b_done[nd] = bus.bin_out;
                end
                nd++;
            end
        end
        bus.start = 1'b0;
        $display("start_busy: dones=%0d at %0d/%0d bins=%0d/%0d", nd, k_done[0], k_done[1], b_done[0], b_done[1]);
        n_checks++;
        if (nd !== 2) begin n_fail++; $display("FAIL busy_done_count: got %0d expected 2", nd); end
        n_checks++;
        if (k_done[0] !== 4 || b_done[0] !== 14'd42) begin
            n_fail++;
            $display("FAIL busy_first: edge %0d bin %0d expected edge 4 bin 42", k_done[0], b_done[0]);
        end
        n_checks++;
        if (k_done[1] !== 10 || b_done[1] !== 14'd777) begin
            n_fail++;
            $display("FAIL busy_second: edge %0d bin %0d expected edge 10 bin 777", k_done[1], b_done[1]);
        end
    endtask

    task automatic test_reset_mid();
        int nd, lat, nb;
        logic [13:0] bin;
        logic e;
        bus.start  = 1'b1;
        bus.bcd_in = 16'h1234;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("reset_mid: busy=%b done=%b bin_out=%0d err=%b", bus.busy, bus.done, bus.bin_out, bus.err);
        n_checks++;
        if ({bus.busy, bus.done, bus.err} !== 3'b000 || bus.bin_out !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b bin=%0d err=%b expected 0/0/0/0",
                     bus.busy, bus.done, bus.bin_out, bus.err);
        end
        nd = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) nd++;
        end
        n_checks++;
        if (nd !== 0) begin n_fail++; $display("FAIL reset_mid_activity: %0d active cycles expected 0", nd); end
        convert(16'h0059, lat, nd, nb, bin, e);
        $display("reset_mid_restart: bcd=0059 lat=%0d bin=%0d err=%b", lat, bin, e);
        n_checks++;
        if (lat !== 4 || bin !== 14'd59 || e !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_restart: lat=%0d bin=%0d err=%b expected 4/59/0", lat, bin, e);
        end
    endtask

    task automatic test_rst_and_start();
        int act;
        rst        = 1'b1;
        bus.start  = 1'b1;
        bus.bcd_in = 16'h0321;
        @(posedge clk); #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        act = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.busy || bus.done) act++;
            @(posedge clk); #1;
        end
        $display("rst_start: active=%0d bin_out=%0d err=%b", act, bus.bin_out, bus.err);
        n_checks++;
        if (act !== 0) begin n_fail++; $display("FAIL rst_start_activity: %0d active cycles expected 0", act); end
        n_checks++;
        if (bus.bin_out !== 14'd0 || bus.err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_start_outputs: bin=%0d err=%b expected 0/0", bus.bin_out, bus.err);
        end
    endtask

    task automatic test_random();
        logic [15:0] bcd;
        int lat, nd, nb, exp_v;
        logic [13:0] bin;
        logic e, exp_e;
        for (int i = 0; i < 24; i++) begin
            for (int j = 0; j < 4; j++) bcd[j*4 +: 4] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) bcd[$urandom_range(0, 3)*4 +: 4] = 4'($urandom_range(10, 15));
            convert(bcd, lat, nd, nb, bin, e);
            model(bcd, exp_v, exp_e);
            $display("random: bcd=%h lat=%0d bin=%0d err=%b expected %0d/%b", bcd, lat, bin, e, exp_v, exp_e);
            n_checks++;
            if (lat !== 4 || nd !== 1 || bin !== 14'(exp_v) || e !== exp_e) begin
                n_fail++;
                $display("FAIL random_conv: bcd=%h lat=%0d pulses=%0d bin=%0d err=%b expected 4/1/%0d/%b",
                         bcd, lat, nd, bin, e, exp_v, exp_e);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_year();
        test_back_to_back();
        test_invalid();
        test_start_while_busy();
        test_reset_mid();
        test_rst_and_start();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
